// File: rtl/ulpi_csr_arbiter.sv
// ulpi_csr_arbiter: round-robin two-master AXI-Lite arbiter in front of the ULPI CSR port, one transaction in flight
module ulpi_csr_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      ulpi_clk,
  input  logic                      ulpi_rst,
  input  logic [ADDR_WIDTH-1:0]     s0_csr_awaddr,
  input  logic [2:0]                s0_csr_awprot,
  input  logic                      s0_csr_awvalid,
  output logic                      s0_csr_awready,
  input  logic [DATA_WIDTH-1:0]     s0_csr_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s0_csr_wstrb,
  input  logic                      s0_csr_wvalid,
  output logic                      s0_csr_wready,
  output logic [1:0]                s0_csr_bresp,
  output logic                      s0_csr_bvalid,
  input  logic                      s0_csr_bready,
  input  logic [ADDR_WIDTH-1:0]     s0_csr_araddr,
  input  logic [2:0]                s0_csr_arprot,
  input  logic                      s0_csr_arvalid,
  output logic                      s0_csr_arready,
  output logic [DATA_WIDTH-1:0]     s0_csr_rdata,
  output logic [1:0]                s0_csr_rresp,
  output logic                      s0_csr_rvalid,
  input  logic                      s0_csr_rready,
  input  logic [ADDR_WIDTH-1:0]     s1_csr_awaddr,
  input  logic [2:0]                s1_csr_awprot,
  input  logic                      s1_csr_awvalid,
  output logic                      s1_csr_awready,
  input  logic [DATA_WIDTH-1:0]     s1_csr_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s1_csr_wstrb,
  input  logic                      s1_csr_wvalid,
  output logic                      s1_csr_wready,
  output logic [1:0]                s1_csr_bresp,
  output logic                      s1_csr_bvalid,
  input  logic                      s1_csr_bready,
  input  logic [ADDR_WIDTH-1:0]     s1_csr_araddr,
  input  logic [2:0]                s1_csr_arprot,
  input  logic                      s1_csr_arvalid,
  output logic                      s1_csr_arready,
  output logic [DATA_WIDTH-1:0]     s1_csr_rdata,
  output logic [1:0]                s1_csr_rresp,
  output logic                      s1_csr_rvalid,
  input  logic                      s1_csr_rready,
  output logic [ADDR_WIDTH-1:0]     m_csr_awaddr,
  output logic [2:0]                m_csr_awprot,
  output logic                      m_csr_awvalid,
  input  logic                      m_csr_awready,
  output logic [DATA_WIDTH-1:0]     m_csr_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_csr_wstrb,
  output logic                      m_csr_wvalid,
  input  logic                      m_csr_wready,
  input  logic [1:0]                m_csr_bresp,
  input  logic                      m_csr_bvalid,
  output logic                      m_csr_bready,
  output logic [ADDR_WIDTH-1:0]     m_csr_araddr,
  output logic [2:0]                m_csr_arprot,
  output logic                      m_csr_arvalid,
  input  logic                      m_csr_arready,
  input  logic [DATA_WIDTH-1:0]     m_csr_rdata,
  input  logic [1:0]                m_csr_rresp,
  input  logic                      m_csr_rvalid,
  output logic                      m_csr_rready,
  output logic                      grant,
  output logic                      busy
);
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA} state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d, aw_done_q, aw_done_d, w_done_q, w_done_d, busy_q, busy_d;
  logic [1:0] req_w, req_r, req;
  logic sel, st_w, st_b, st_ar, st_r, aw_hs, w_hs;
  always_comb begin
    req_w = {s1_csr_awvalid, s0_csr_awvalid};
    req_r = {s1_csr_arvalid, s0_csr_arvalid};
    req = req_w | req_r;
    sel = (req == 2'b11) ? ~grant_q : req[1];
    st_w = state_q == WRITE;
    st_b = state_q == WRESP;
    st_ar = state_q == READ;
    st_r = state_q == RDATA;
    // payloads always follow grant so the downstream port never sees X in IDLE
    m_csr_awaddr = grant_q ? s1_csr_awaddr : s0_csr_awaddr;
    m_csr_awprot = grant_q ? s1_csr_awprot : s0_csr_awprot;
    m_csr_wdata = grant_q ? s1_csr_wdata : s0_csr_wdata;
    m_csr_wstrb = grant_q ? s1_csr_wstrb : s0_csr_wstrb;
    m_csr_araddr = grant_q ? s1_csr_araddr : s0_csr_araddr;
    m_csr_arprot = grant_q ? s1_csr_arprot : s0_csr_arprot;
    m_csr_awvalid = st_w & ~aw_done_q & (grant_q ? s1_csr_awvalid : s0_csr_awvalid);
    m_csr_wvalid = st_w & ~w_done_q & (grant_q ? s1_csr_wvalid : s0_csr_wvalid);
    m_csr_bready = st_b & (grant_q ? s1_csr_bready : s0_csr_bready);
    m_csr_arvalid = st_ar & (grant_q ? s1_csr_arvalid : s0_csr_arvalid);
    m_csr_rready = st_r & (grant_q ? s1_csr_rready : s0_csr_rready);
    s0_csr_awready = st_w & ~grant_q & ~aw_done_q & m_csr_awready;
    s1_csr_awready = st_w & grant_q & ~aw_done_q & m_csr_awready;
    s0_csr_wready = st_w & ~grant_q & ~w_done_q & m_csr_wready;
    s1_csr_wready = st_w & grant_q & ~w_done_q & m_csr_wready;
    s0_csr_bvalid = st_b & ~grant_q & m_csr_bvalid;
    s1_csr_bvalid = st_b & grant_q & m_csr_bvalid;
    s0_csr_bresp = m_csr_bresp;
    s1_csr_bresp = m_csr_bresp;
    s0_csr_arready = st_ar & ~grant_q & m_csr_arready;
    s1_csr_arready = st_ar & grant_q & m_csr_arready;
    s0_csr_rvalid = st_r & ~grant_q & m_csr_rvalid;
    s1_csr_rvalid = st_r & grant_q & m_csr_rvalid;
    s0_csr_rdata = m_csr_rdata;
    s1_csr_rdata = m_csr_rdata;
    s0_csr_rresp = m_csr_rresp;
    s1_csr_rresp = m_csr_rresp;
    aw_hs = m_csr_awvalid & m_csr_awready;
    w_hs = m_csr_wvalid & m_csr_wready;
    state_d = state_q;
    grant_d = grant_q;
    aw_done_d = aw_done_q | aw_hs;
    w_done_d = w_done_q | w_hs;
    case (state_q)
      IDLE: if (|req) begin
        grant_d = sel;
        state_d = req_w[sel] ? WRITE : READ;
      end
      WRITE: if (aw_done_d & w_done_d) begin
        state_d = WRESP;
        aw_done_d = 1'b0;
        w_done_d = 1'b0;
      end
      WRESP: state_d = (m_csr_bvalid & m_csr_bready) ? IDLE : WRESP;
      READ: state_d = (m_csr_arvalid & m_csr_arready) ? RDATA : READ;
      RDATA: state_d = (m_csr_rvalid & m_csr_rready) ? IDLE : RDATA;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge ulpi_clk) begin
    if (ulpi_rst) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      aw_done_q <= aw_done_d;
      w_done_q <= w_done_d;
      busy_q <= busy_d;
    end
  end
  assign grant = grant_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_ulpi_csr_arbiter.sv
// tb_ulpi_csr_arbiter: directed two-master traffic against a CSR slave model, scoreboard-checked
module tb_ulpi_csr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [1:0][31:0] s_awaddr, s_wdata, s_araddr;
  logic [1:0][2:0] s_awprot, s_arprot;
  logic [1:0][3:0] s_wstrb;
  logic [1:0] s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid;
  logic s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid;
  logic [1:0] s0_bresp, s0_rresp, s1_bresp, s1_rresp;
  logic [31:0] s0_rdata, s1_rdata;
  logic [1:0] s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  assign s_awready = {s1_awready, s0_awready};
  assign s_wready = {s1_wready, s0_wready};
  assign s_bvalid = {s1_bvalid, s0_bvalid};
  assign s_arready = {s1_arready, s0_arready};
  assign s_rvalid = {s1_rvalid, s0_rvalid};
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0] m_awprot, m_arprot;
  logic [3:0] m_wstrb;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0] m_bresp, m_rresp;
  logic grant, busy;

  ulpi_csr_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .ulpi_clk(clk), .ulpi_rst(rst),
    .s0_csr_awaddr(s_awaddr[0]), .s0_csr_awprot(s_awprot[0]), .s0_csr_awvalid(s_awvalid[0]), .s0_csr_awready(s0_awready),
    .s0_csr_wdata(s_wdata[0]), .s0_csr_wstrb(s_wstrb[0]), .s0_csr_wvalid(s_wvalid[0]), .s0_csr_wready(s0_wready),
    .s0_csr_bresp(s0_bresp), .s0_csr_bvalid(s0_bvalid), .s0_csr_bready(s_bready[0]),
    .s0_csr_araddr(s_araddr[0]), .s0_csr_arprot(s_arprot[0]), .s0_csr_arvalid(s_arvalid[0]), .s0_csr_arready(s0_arready),
    .s0_csr_rdata(s0_rdata), .s0_csr_rresp(s0_rresp), .s0_csr_rvalid(s0_rvalid), .s0_csr_rready(s_rready[0]),
    .s1_csr_awaddr(s_awaddr[1]), .s1_csr_awprot(s_awprot[1]), .s1_csr_awvalid(s_awvalid[1]), .s1_csr_awready(s1_awready),
    .s1_csr_wdata(s_wdata[1]), .s1_csr_wstrb(s_wstrb[1]), .s1_csr_wvalid(s_wvalid[1]), .s1_csr_wready(s1_wready),
    .s1_csr_bresp(s1_bresp), .s1_csr_bvalid(s1_bvalid), .s1_csr_bready(s_bready[1]),
    .s1_csr_araddr(s_araddr[1]), .s1_csr_arprot(s_arprot[1]), .s1_csr_arvalid(s_arvalid[1]), .s1_csr_arready(s1_arready),
    .s1_csr_rdata(s1_rdata), .s1_csr_rresp(s1_rresp), .s1_csr_rvalid(s1_rvalid), .s1_csr_rready(s_rready[1]),
    .m_csr_awaddr(m_awaddr), .m_csr_awprot(m_awprot), .m_csr_awvalid(m_awvalid), .m_csr_awready(m_awready),
    .m_csr_wdata(m_wdata), .m_csr_wstrb(m_wstrb), .m_csr_wvalid(m_wvalid), .m_csr_wready(m_wready),
    .m_csr_bresp(m_bresp), .m_csr_bvalid(m_bvalid), .m_csr_bready(m_bready),
    .m_csr_araddr(m_araddr), .m_csr_arprot(m_arprot), .m_csr_arvalid(m_arvalid), .m_csr_arready(m_arready),
    .m_csr_rdata(m_rdata), .m_csr_rresp(m_rresp), .m_csr_rvalid(m_rvalid), .m_csr_rready(m_rready),
    .grant(grant), .busy(busy)
  );

  typedef struct packed {logic w; logic idx; logic [31:0] addr; logic [31:0] data;} txn_t;
  txn_t exp_m[$];
  logic [1:0] exp_b0[$], exp_b1[$];
  logic [33:0] exp_r0[$], exp_r1[$];
  logic [31:0] mem [16];
  logic [31:0] s0_stream [4];
  logic [31:0] s1_stream [4];
  int aw_stall = 0;
  int r_delay = 0;
  logic [1:0] next_bresp = 2'b00;
  logic b2b = 1'b0;
  int cyc = 0;
  int ntx = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_u(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: handshake missing or unexpected", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pm(input logic w, input logic idx, input logic [31:0] a, input logic [31:0] d);
    exp_m.push_back('{w: w, idx: idx, addr: a, data: d});
  endtask

  task automatic mwrite(input int i, input logic [31:0] a, input logic [31:0] d, input int lead, input logic [1:0] eb);
    logic awd, wd, bd;
    int n;
    if (i == 0) exp_b0.push_back(eb);
    else exp_b1.push_back(eb);
    s_wdata[i] = d;
    s_wstrb[i] = 4'hF;
    s_awaddr[i] = a;
    s_awprot[i] = (i != 0) ? 3'b010 : 3'b001;
    if (lead > 0) begin
      s_wvalid[i] = 1'b1;
      repeat (lead) step();
    end
    s_awvalid[i] = 1'b1;
    s_wvalid[i] = 1'b1;
    awd = 1'b0;
    wd = 1'b0;
    n = 0;
    while (!(awd && wd) && n < 40) begin
      @(negedge clk);
      awd = awd | (s_awvalid[i] & s_awready[i]);
      wd = wd | (s_wvalid[i] & s_wready[i]);
      step();
      n++;
      if (awd) s_awvalid[i] = 1'b0;
      if (wd) s_wvalid[i] = 1'b0;
    end
    if (!(awd && wd)) fail_u($sformatf("s%0d_aw_w_timeout", i));
    s_awvalid[i] = 1'b0;
    s_wvalid[i] = 1'b0;
    s_bready[i] = 1'b1;
    bd = 1'b0;
    n = 0;
    while (!bd && n < 40) begin
      @(negedge clk);
      bd = s_bvalid[i];
      step();
      n++;
    end
    s_bready[i] = 1'b0;
    if (!bd) fail_u($sformatf("s%0d_b_timeout", i));
  endtask

  task automatic mread(input int i, input logic [31:0] a, input logic [31:0] d);
    logic hs;
    int n;
    if (i == 0) exp_r0.push_back({2'b00, d});
    else exp_r1.push_back({2'b00, d});
    s_araddr[i] = a;
    s_arprot[i] = (i != 0) ? 3'b010 : 3'b001;
    s_arvalid[i] = 1'b1;
    hs = 1'b0;
    n = 0;
    while (!hs && n < 40) begin
      @(negedge clk);
      hs = s_arready[i];
      step();
      n++;
    end
    s_arvalid[i] = 1'b0;
    if (!hs) fail_u($sformatf("s%0d_ar_timeout", i));
    s_rready[i] = 1'b1;
    hs = 1'b0;
    n = 0;
    while (!hs && n < 40) begin
      @(negedge clk);
      hs = s_rvalid[i];
      step();
      n++;
    end
    s_rready[i] = 1'b0;
    if (!hs) fail_u($sformatf("s%0d_r_timeout", i));
  endtask

  // CSR slave model plus downstream-side monitor: ordering, single outstanding, bubble, W not repeated
  initial begin : slave
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, r_rst, aw_v, aw_got, w_got, rpend, active, w_seen, prev_b2b;
    logic [31:0] sa, sd, sra, a_q, d_q, ra;
    int rcnt, last_resp;
    logic pend;
    txn_t cur;
    aw_got = 1'b0; w_got = 1'b0; rpend = 1'b0; active = 1'b0; w_seen = 1'b0; prev_b2b = 1'b0; pend = 1'b0;
    a_q = '0; d_q = '0; ra = '0; rcnt = 0; last_resp = -100; cur = '0;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      r_rst = rst;
      aw_v = m_awvalid;
      aw_hs = m_awvalid & m_awready;
      w_hs = m_wvalid & m_wready;
      b_hs = m_bvalid & m_bready;
      ar_hs = m_arvalid & m_arready;
      r_hs = m_rvalid & m_rready;
      sa = m_awaddr;
      sd = m_wdata;
      sra = m_araddr;
      if (!r_rst) begin
        if (!active && (m_awvalid || m_wvalid || m_arvalid)) begin
          if (exp_m.size() == 0) fail_u("m_csr_unexpected_txn");
          else begin
            cur = exp_m.pop_front();
            active = 1'b1;
            w_seen = 1'b0;
            chk("m_dir", m_awvalid, cur.w);
            chk("m_grant", grant, cur.idx);
            chk("m_addr", m_awvalid ? m_awaddr : m_araddr, cur.addr);
            chk("m_prot", m_awvalid ? m_awprot : m_arprot, cur.idx ? 3'b010 : 3'b001);
            chk("m_gap_min", (cyc - last_resp) >= 2, 1);
            if (b2b && prev_b2b) chk("m_bubble", cyc - last_resp, 2);
            prev_b2b = b2b;
          end
        end
        if (aw_hs || ar_hs) begin
          chk("one_outstanding", pend, 0);
          pend = 1'b1;
          ntx++;
        end
        if (w_hs) begin
          chk("w_once", w_seen, 0);
          chk("m_wdata", m_wdata, cur.data);
          chk("m_wstrb", m_wstrb, 4'hF);
          w_seen = 1'b1;
        end
        if (b_hs || r_hs) begin
          pend = 1'b0;
          active = 1'b0;
          last_resp = cyc;
        end
      end
      @(posedge clk);
      #1;
      if (r_rst) begin
        aw_got = 1'b0; w_got = 1'b0; rpend = 1'b0; m_bvalid = 1'b0; m_rvalid = 1'b0;
        active = 1'b0; pend = 1'b0; prev_b2b = 1'b0;
      end else begin
        if (aw_v && !m_awready && aw_stall > 0) aw_stall--;
        if (aw_hs) begin aw_got = 1'b1; a_q = sa; end
        if (w_hs) begin w_got = 1'b1; d_q = sd; end
        if (b_hs) m_bvalid = 1'b0;
        if (aw_got && w_got) begin
          mem[a_q[5:2]] = d_q;
          m_bvalid = 1'b1;
          m_bresp = next_bresp;
          next_bresp = 2'b00;
          aw_got = 1'b0;
          w_got = 1'b0;
        end
        if (r_hs) m_rvalid = 1'b0;
        if (ar_hs) begin rpend = 1'b1; ra = sra; rcnt = r_delay; end
        if (rpend) begin
          if (rcnt == 0) begin
            m_rvalid = 1'b1;
            m_rdata = mem[ra[5:2]];
            m_rresp = 2'b00;
            rpend = 1'b0;
          end else rcnt--;
        end
      end
      m_awready = (aw_stall == 0);
    end
  end

  // requester-side monitor: every B/R handshake is matched against that port's expected queue
  initial begin : resp_mon
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (s0_bvalid && s_bready[0]) begin
          if (exp_b0.size() == 0) fail_u("s0_b_unexpected");
          else chk("s0_bresp", s0_bresp, exp_b0.pop_front());
        end
        if (s1_bvalid && s_bready[1]) begin
          if (exp_b1.size() == 0) fail_u("s1_b_unexpected");
          else chk("s1_bresp", s1_bresp, exp_b1.pop_front());
        end
        if (s0_rvalid && s_rready[0]) begin
          if (exp_r0.size() == 0) fail_u("s0_r_unexpected");
          else chk("s0_rresp_rdata", {s0_rresp, s0_rdata}, exp_r0.pop_front());
        end
        if (s1_rvalid && s_rready[1]) begin
          if (exp_r1.size() == 0) fail_u("s1_r_unexpected");
          else chk("s1_rresp_rdata", {s1_rresp, s1_rdata}, exp_r1.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0, hs;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0; s_awprot = '0; s_arprot = '0; s_wstrb = '0;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    for (int k = 0; k < 16; k++) mem[k] = 32'hB000_0000 | k;
    mem[4] = 32'hA5A5_0001;
    s0_stream[0] = 32'hB000_000C; s0_stream[1] = 32'hB000_000D;
    s0_stream[2] = 32'hB000_000E; s0_stream[3] = 32'hB000_000F;
    s1_stream[0] = 32'h1111_0000; s1_stream[1] = 32'h2222_0000;
    s1_stream[2] = 32'h3333_0000; s1_stream[3] = 32'hB000_000B;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 1);
    chk("rst_m_valid_ready", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    chk("rst_s_valid_ready", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, 0);
    step();
    rst = 1'b0;
    // single s0 read, one-cycle arbitration latency
    pm(1'b0, 1'b0, 32'h10, 32'h0);
    fork
      mread(0, 32'h10, 32'hA5A5_0001);
      begin
        @(negedge clk);
        chk("lat_idle_arvalid", m_arvalid, 0);
        chk("lat_idle_busy", busy, 0);
        @(negedge clk);
        chk("lat_grant_arvalid", m_arvalid, 1);
        chk("lat_grant_busy", busy, 1);
      end
    join
    @(negedge clk);
    chk("t1_grant", grant, 0);
    chk("t1_busy", busy, 0);
    step();
    // simultaneous writes right after reset: s0 wins the tie
    rst = 1'b1;
    step();
    rst = 1'b0;
    pm(1'b1, 1'b0, 32'h20, 32'h1111_0000);
    pm(1'b1, 1'b1, 32'h24, 32'h2222_0000);
    b2b = 1'b1;
    fork
      mwrite(0, 32'h20, 32'h1111_0000, 0, 2'b00);
      mwrite(1, 32'h24, 32'h2222_0000, 0, 2'b00);
    join
    b2b = 1'b0;
    @(negedge clk);
    chk("t2_grant", grant, 1);
    step();
    // s1 write with early W and a stalled AW; SLVERR passes through
    aw_stall = 2;
    next_bresp = 2'b10;
    pm(1'b1, 1'b1, 32'h28, 32'h3333_0000);
    mwrite(1, 32'h28, 32'h3333_0000, 3, 2'b10);
    // same master write and read together: write first, read sees new data
    pm(1'b1, 1'b0, 32'h04, 32'h0000_00C3);
    pm(1'b0, 1'b0, 32'h04, 32'h0);
    fork
      mwrite(0, 32'h04, 32'h0000_00C3, 0, 2'b00);
      mread(0, 32'h04, 32'h0000_00C3);
    join
    @(negedge clk);
    chk("t4_grant", grant, 0);
    step();
    // both masters stream 8 reads: strict alternation starting with s1
    for (int k = 0; k < 8; k++) begin
      pm(1'b0, 1'b1, 32'h20 + 32'(4 * (k % 4)), 32'h0);
      pm(1'b0, 1'b0, 32'h30 + 32'(4 * (k % 4)), 32'h0);
    end
    n0 = ntx;
    b2b = 1'b1;
    fork
      for (int k = 0; k < 8; k++) mread(0, 32'h30 + 32'(4 * (k % 4)), s0_stream[k % 4]);
      for (int j = 0; j < 8; j++) mread(1, 32'h20 + 32'(4 * (j % 4)), s1_stream[j % 4]);
    join
    b2b = 1'b0;
    chk("t5_txn_count", ntx - n0, 16);
    // reset while waiting in RDATA
    r_delay = 20;
    pm(1'b0, 1'b0, 32'h08, 32'h0);
    s_araddr[0] = 32'h08;
    s_arprot[0] = 3'b001;
    s_arvalid[0] = 1'b1;
    hs = 0;
    for (int k = 0; k < 20 && hs == 0; k++) begin
      @(negedge clk);
      hs = int'(s0_arready);
      step();
    end
    if (hs == 0) fail_u("t6_ar_timeout");
    s_arvalid[0] = 1'b0;
    s_rready[0] = 1'b1;
    @(negedge clk);
    chk("t6_rdata_busy", busy, 1);
    chk("t6_rdata_rready", {m_rready, m_rvalid}, 2'b10);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    s_rready[0] = 1'b0;
    r_delay = 0;
    @(negedge clk);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_grant", grant, 1);
    chk("t6_rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, s_bvalid, s_rvalid}, 0);
    step();
    pm(1'b0, 1'b1, 32'h0C, 32'h0);
    mread(1, 32'h0C, 32'hB000_0003);
    repeat (2) step();
    chk("queues_drained", exp_m.size() + exp_b0.size() + exp_b1.size() + exp_r0.size() + exp_r1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
